// File: rtl/step_sequencer_engine_pkg.sv
// Shared definitions for the step sequencer engine: FSM encodings and step-period floor.
package step_sequencer_engine_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Shortest usable step; a period of 0 or 1 would make clk_cnt wrap every cycle or never.
  localparam int unsigned MIN_STEP_PERIOD = 2;

  function automatic logic [31:0] eff_period(input logic [31:0] p);
    return (p < 32'(MIN_STEP_PERIOD)) ? 32'(MIN_STEP_PERIOD) : p;
  endfunction

endpackage

// File: rtl/step_sequencer_engine_if.sv
// Sample-write handshake between the sequencer engine and the audio codec controller.
interface step_sequencer_engine_if;

  logic        write_audio_out;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  modport master (
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out,
    input  audio_out_allowed
  );

  modport slave (
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out,
    output audio_out_allowed
  );

endinterface

// File: rtl/step_sequencer_engine_step_timer.sv
// Step timer: run/idle control, clocks-per-step counter, step index and loop counting.
module step_sequencer_engine_step_timer
  import step_sequencer_engine_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      step_period,
  input  logic [7:0]       loops,
  output logic             play,
  output logic             step_pulse,
  output logic [IDX_W-1:0] step_idx,
  output logic             enter_step,
  output logic [IDX_W-1:0] next_idx,
  output logic             halt
);

  state_t           state_q;
  logic [31:0]      clk_cnt_q;
  logic [31:0]      period_q;
  logic [7:0]       loop_cnt_q;
  logic [IDX_W-1:0] step_idx_q;
  logic             step_pulse_q;

  logic       at_end;
  logic       last_step;
  logic       finish;
  logic [7:0] loop_next;

  // Step boundary decode; start outranks a terminating wrap, stop outranks everything.
  always_comb begin
    at_end     = (state_q == ST_RUN) && (clk_cnt_q == period_q - 32'd1);
    last_step  = (step_idx_q == IDX_W'(NUM_STEPS - 1));
    loop_next  = loop_cnt_q + 8'd1;
    finish     = at_end && last_step && (loops != 8'd0) && (loop_next == loops);
    halt       = stop || (finish && !start);
    enter_step = !stop && (start || (at_end && !finish));
    next_idx   = start ? '0 : step_idx_q + 1'b1;
  end

  // FSM and counters.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      period_q     <= '0;
      loop_cnt_q   <= '0;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b0;
    end else if (stop) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      loop_cnt_q   <= '0;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b0;
    end else if (start) begin
      state_q      <= ST_RUN;
      clk_cnt_q    <= '0;
      period_q     <= eff_period(step_period);
      loop_cnt_q   <= '0;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b1;
    end else if (state_q == ST_RUN) begin
      if (at_end) begin
        clk_cnt_q    <= '0;
        period_q     <= eff_period(step_period);
        step_pulse_q <= 1'b1;
        if (finish) begin
          state_q    <= ST_IDLE;
          step_idx_q <= '0;
          loop_cnt_q <= '0;
        end else begin
          step_idx_q <= next_idx;
          if (last_step) begin
            loop_cnt_q <= loop_next;
          end
        end
      end else begin
        clk_cnt_q    <= clk_cnt_q + 32'd1;
        step_pulse_q <= 1'b0;
      end
    end else begin
      step_pulse_q <= 1'b0;
    end
  end

  assign play       = (state_q == ST_RUN);
  assign step_pulse = step_pulse_q;
  assign step_idx   = step_idx_q;

endmodule

// File: rtl/step_sequencer_engine.sv
// Step sequencer playback engine: pattern store, tone mixer with saturation, and a
// rate-divided sample holder feeding the codec write handshake.
module step_sequencer_engine
  import step_sequencer_engine_pkg::*;
#(
  parameter int unsigned NUM_TONES  = 12,
  parameter int unsigned NUM_STEPS  = 16,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned MIX_SHIFT  = 2,
  parameter int unsigned SAMPLE_DIV = 1042,
  localparam int unsigned IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic [31:0]                   step_period,
  input  logic [7:0]                    loops,
  input  logic                          pat_we,
  input  logic [IDX_W-1:0]              pat_addr,
  input  logic [NUM_TONES-1:0]          pat_data,
  input  logic [NUM_TONES*SAMPLE_W-1:0] tone_samples,
  step_sequencer_engine_if.master       audio,
  output logic                          play,
  output logic                          step_pulse,
  output logic [IDX_W-1:0]              step_idx,
  output logic [NUM_TONES-1:0]          active_tones,
  output logic                          overrun
);

  localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_TONES) + 1;
  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (SAMPLE_W - 1)));

  logic             enter_step;
  logic             halt;
  logic [IDX_W-1:0] next_idx;

  step_sequencer_engine_step_timer #(
    .NUM_STEPS (NUM_STEPS),
    .IDX_W     (IDX_W)
  ) u_step_timer (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .step_period (step_period),
    .loops       (loops),
    .play        (play),
    .step_pulse  (step_pulse),
    .step_idx    (step_idx),
    .enter_step  (enter_step),
    .next_idx    (next_idx),
    .halt        (halt)
  );

  logic [NUM_TONES-1:0] pattern_q [NUM_STEPS];
  logic [NUM_TONES-1:0] active_tones_q;
  logic [NUM_TONES-1:0] row_next;

  // Pattern rows; writes accepted in any state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pattern_q <= '{default: '0};
    end else if (pat_we) begin
      pattern_q[pat_addr] <= pat_data;
    end
  end

  // Bypass so a row written in the same cycle the step is entered is the one latched.
  assign row_next = (pat_we && (pat_addr == next_idx)) ? pat_data : pattern_q[next_idx];

  // Row latched at each step entry; cleared when playback halts.
  always_ff @(posedge CLOCK_50) begin
    if (reset || halt) begin
      active_tones_q <= '0;
    end else if (enter_step) begin
      active_tones_q <= row_next;
    end
  end

  assign active_tones = active_tones_q;

  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    shifted;
  logic signed [SAMPLE_W-1:0] tone;
  logic signed [SAMPLE_W-1:0] mix_d;
  logic signed [SAMPLE_W-1:0] mix_q;

  // Sum of enabled tones, scaled and clamped; silence while not playing.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_TONES; i++) begin
      tone = tone_samples[i*SAMPLE_W +: SAMPLE_W];
      if (active_tones_q[i]) begin
        sum = sum + SUM_W'(tone);
      end
    end
    shifted = sum >>> MIX_SHIFT;
    if (shifted > SAT_MAX) begin
      mix_d = SAMPLE_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      mix_d = SAMPLE_W'(SAT_MIN);
    end else begin
      mix_d = SAMPLE_W'(shifted);
    end
    if (!play) begin
      mix_d = '0;
    end
  end

  // Registered mix.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  logic [DIV_W-1:0]           div_cnt_q;
  logic signed [SAMPLE_W-1:0] holder_q;
  logic                       full_q;
  logic                       overrun_q;
  logic                       write_q;
  logic [31:0]                out_q;
  logic                       tick;
  logic                       wr;

  assign tick = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign wr   = full_q && audio.audio_out_allowed;

  // Sample-rate divider, single-entry holder and codec write strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt_q <= '0;
      holder_q  <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      write_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      write_q   <= wr;
      if (wr) begin
        out_q <= 32'(holder_q);
      end
      if (tick) begin
        holder_q <= mix_q;
        full_q   <= 1'b1;
        if (full_q) begin
          overrun_q <= 1'b1;
        end
      end else if (wr) begin
        full_q <= 1'b0;
      end
    end
  end

  assign audio.write_audio_out         = write_q;
  assign audio.left_channel_audio_out  = out_q;
  assign audio.right_channel_audio_out = out_q;
  assign overrun                       = overrun_q;

endmodule
